// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU write port and UART status/serial bundle
// Signals:
//   uart_w_enable  CPU -> UART  write strobe, one byte per high cycle
//   uart_w_data    CPU -> UART  byte to queue
//   uart_w_ready   UART -> CPU  FIFO has room
//   tx             UART -> line 8N1 serial output, idle high
//   busy           UART -> CPU  frame in flight or bytes queued
//   fifo_count     UART -> CPU  queued bytes, excluding the one being shifted
//   overflow       UART -> CPU  sticky: a write was dropped while full
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic                uart_w_enable;
    logic [7:0]          uart_w_data;
    logic                uart_w_ready;
    logic                tx;
    logic                busy;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                overflow;
    modport master (
        output uart_w_enable, uart_w_data,
        input  uart_w_ready, tx, busy, fifo_count, overflow
    );
    modport slave (
        input  uart_w_enable, uart_w_data,
        output uart_w_ready, tx, busy, fifo_count, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  uart_tx_fifo_if.slave: CPU write port, serial tx and status
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH_LOG2   = 3
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL = CW'(1 << DEPTH_LOG2);
    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
    logic [7:0]            mem_q [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic [1:0]            state_q, state_d;
    logic [15:0]           baud_q, baud_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            sh_q, sh_d;
    logic                  tx_q, tx_d;
    logic                  push, pop, baud_end;
    assign baud_end = baud_q == BAUD_MAX;
    // Fullness is judged before the edge, so a same-edge pop never frees room for a write.
    assign push = bus.uart_w_enable && cnt_q != FULL;
    // Pop when idle, or at the end of a stop bit so the next start bit follows with no gap.
    assign pop = cnt_q != '0 && (state_q == IDLE || (state_q == STOP && baud_end));
    always_comb begin
        wp_d    = push ? wp_q + 1'b1 : wp_q;
        rp_d    = pop ? rp_q + 1'b1 : rp_q;
        cnt_d   = cnt_q + CW'(push) - CW'(pop);
        ovf_d   = ovf_q || (bus.uart_w_enable && cnt_q == FULL);
        state_d = state_q;
        baud_d  = baud_end ? '0 : baud_q + 1'b1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (pop) begin
                    state_d = START;
                    sh_d    = mem_q[rp_q];
                end
            end
            START: if (baud_end) begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA: if (baud_end) begin
                sh_d  = sh_q >> 1;
                idx_d = idx_q + 1'b1;
                if (idx_q == 3'd7) state_d = STOP;
            end
            default: if (baud_end) begin
                state_d = pop ? START : IDLE;
                if (pop) sh_d = mem_q[rp_q];
            end
        endcase
        // tx is derived from the next state so the line register changes on the same edge as the FSM.
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= bus.uart_w_data;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end
    assign bus.uart_w_ready = cnt_q != FULL;
    assign bus.tx           = tx_q;
    assign bus.busy         = state_q != IDLE || cnt_q != '0;
    assign bus.fifo_count   = cnt_q;
    assign bus.overflow     = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench, serial frames decoded and matched against pushed bytes
module tb_uart_tx_fifo;
    localparam int CPB = 4;
    localparam int DL  = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    logic       mon_on = 1'b0;
    int         mon_wait = 0;
    int         mon_bit = 0;
    logic [7:0] mon_byte = '0;
    uart_tx_fifo_if #(.DEPTH_LOG2(DL)) bus ();
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic steps(input int n);
        repeat (n) step();
    endtask
    task automatic wr(input logic [7:0] b);
        bus.uart_w_enable = 1'b1;
        bus.uart_w_data   = b;
    endtask
    task automatic wr_push(input logic [7:0] b);
        wr(b);
        exp_q.push_back(b);
    endtask
    task automatic wr_off();
        bus.uart_w_enable = 1'b0;
    endtask
    task automatic wait_idle(input int lim);
        int n = 0;
        while ((bus.busy || mon_on) && n < lim) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n < lim), 1);
    endtask
    // Serial monitor: samples the middle of every bit on the falling clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            mon_on = 1'b0;
        end else if (!mon_on) begin
            if (bus.tx === 1'b0) begin
                mon_on   = 1'b1;
                mon_wait = CPB / 2;
                mon_bit  = 0;
            end
        end else begin
            mon_wait = mon_wait - 1;
            if (mon_wait == 0) begin
                mon_wait = CPB;
                if (mon_bit == 0) chk("start_bit", 32'(bus.tx), 0);
                else if (mon_bit < 9) mon_byte = {bus.tx, mon_byte[7:1]};
                else begin
                    chk("stop_bit", 32'(bus.tx), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", mon_byte);
                    end else chk("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                    mon_on = 1'b0;
                end
                mon_bit++;
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        bus.uart_w_enable = 1'b0;
        bus.uart_w_data   = '0;
        #2 rst = 1'b0;
        steps(3);
        chk("rst_tx", 32'(bus.tx), 1);
        chk("rst_count", 32'(bus.fifo_count), 0);
        chk("rst_ready", 32'(bus.uart_w_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        rst = 1'b1;
        // single byte, accepted on the first edge after release
        wr_push(8'hA5);
        step();
        wr_off();
        chk("t1_count", 32'(bus.fifo_count), 1);
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_tx_pre", 32'(bus.tx), 1);
        step();
        chk("t1_tx_start", 32'(bus.tx), 0);
        chk("t1_count_pop", 32'(bus.fifo_count), 0);
        steps(39);
        chk("t1_busy_stop", 32'(bus.busy), 1);
        chk("t1_tx_stop", 32'(bus.tx), 1);
        step();
        chk("t1_busy_end", 32'(bus.busy), 0);
        // 0x00 and 0xFF queued behind a frame in flight, then sent back to back
        wr_push(8'h5A);
        step();
        wr_off();
        step();
        chk("t2_tx_start0", 32'(bus.tx), 0);
        wr_push(8'h00);
        step();
        chk("t2_count1", 32'(bus.fifo_count), 1);
        wr_push(8'hFF);
        step();
        wr_off();
        chk("t2_count2", 32'(bus.fifo_count), 2);
        steps(37);
        chk("t2_stop0", 32'(bus.tx), 1);
        step();
        chk("t2_start1", 32'(bus.tx), 0);
        chk("t2_count1b", 32'(bus.fifo_count), 1);
        steps(39);
        chk("t2_stop1", 32'(bus.tx), 1);
        step();
        chk("t2_start2", 32'(bus.tx), 0);
        chk("t2_count0", 32'(bus.fifo_count), 0);
        steps(40);
        chk("t2_busy_end", 32'(bus.busy), 0);
        // nine writes in a row while idle, then a tenth into a full FIFO
        for (int j = 1; j <= 9; j++) begin
            wr_push(8'(8'h0F + j));
            step();
            chk("t3_count", 32'(bus.fifo_count), j == 1 ? 1 : j - 1);
            chk("t3_ready", 32'(bus.uart_w_ready), 32'(j != 9));
        end
        chk("t3_ovf_clear", 32'(bus.overflow), 0);
        wr(8'hEE);
        step();
        wr_off();
        chk("t3_ovf_set", 32'(bus.overflow), 1);
        chk("t3_count_full", 32'(bus.fifo_count), 8);
        chk("t3_ready_full", 32'(bus.uart_w_ready), 0);
        wait_idle(600);
        // reset in the middle of 0x3C's data bits with three bytes queued
        wr(8'h3C);
        step();
        wr(8'h11);
        step();
        wr(8'h22);
        step();
        wr(8'h33);
        step();
        wr_off();
        chk("t5_count3", 32'(bus.fifo_count), 3);
        steps(7);
        chk("t5_tx_bit1", 32'(bus.tx), 0);
        rst = 1'b0;
        #1;
        chk("t5_tx", 32'(bus.tx), 1);
        chk("t5_count", 32'(bus.fifo_count), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_ready", 32'(bus.uart_w_ready), 1);
        chk("t5_overflow", 32'(bus.overflow), 0);
        steps(2);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            chk("t5_quiet", 32'({bus.tx, bus.busy}), 32'b10);
        end
        // write on the very edge the stop bit ends and the head is popped
        for (int j = 0; j < 9; j++) begin
            wr_push(8'(8'h40 + j));
            step();
        end
        wr_off();
        chk("t4_count8", 32'(bus.fifo_count), 8);
        steps(32);
        chk("t4_count8b", 32'(bus.fifo_count), 8);
        chk("t4_ovf_clear", 32'(bus.overflow), 0);
        wr(8'hEE);
        step();
        wr_off();
        chk("t4_count7", 32'(bus.fifo_count), 7);
        chk("t4_ovf_set", 32'(bus.overflow), 1);
        chk("t4_ready", 32'(bus.uart_w_ready), 1);
        wait_idle(600);
        // 20 bytes in bursts of five to walk the pointers around twice
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 5; i++) begin
                wr_push(8'(b * 5 + i + 1));
                step();
            end
            wr_off();
            wait_idle(400);
        end
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
